// File: rtl/bitwise_logic_pkg.sv
// rtl/bitwise_logic_pkg.sv - op codes and FSM encoding for the sequential bitwise logic unit
package bitwise_logic_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - combinational C-bit slice of the eight bitwise operations
module logic_slice
    import bitwise_logic_pkg::*;
#(
    parameter int C = 2
) (
    input  logic [2:0]   op,
    input  logic [C-1:0] a_s,
    input  logic [C-1:0] b_s,
    output logic [C-1:0] y_s
);

    for (genvar i = 0; i < C; i++) begin : g_bit
        logic y_bit;

        // per-bit gate with an 8-way select on the op code
        always_comb begin
            y_bit = a_s[i];
            case (op)
                OP_NOT:  y_bit = ~a_s[i];
                OP_AND:  y_bit = a_s[i] & b_s[i];
                OP_OR:   y_bit = a_s[i] | b_s[i];
                OP_XOR:  y_bit = a_s[i] ^ b_s[i];
                OP_NAND: y_bit = ~(a_s[i] & b_s[i]);
                OP_NOR:  y_bit = ~(a_s[i] | b_s[i]);
                OP_XNOR: y_bit = ~(a_s[i] ^ b_s[i]);
                OP_PASS: y_bit = a_s[i];
                default: y_bit = a_s[i];
            endcase
        end

        assign y_s[i] = y_bit;
    end

endmodule

// File: rtl/bitwise_logic_seq.sv
// rtl/bitwise_logic_seq.sv - multi-cycle bitwise logic unit, C bits per cycle, with zero/parity flags
module bitwise_logic_seq
    import bitwise_logic_pkg::*;
#(
    parameter int N = 8,
    parameter int C = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         parity
);

    localparam int S     = N / C;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;

    if ((C < 1) || (N % C != 0)) begin : g_bad_params
        $error("bitwise_logic_seq: N must be a positive multiple of C");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [2:0]       op_q;
    logic [N-1:0]     result_q;
    logic [C-1:0]     a_s;
    logic [C-1:0]     b_s;
    logic [C-1:0]     y_s;
    logic             accept;
    logic             last;

    // in_ready is masked by rst so nothing is accepted while reset is held
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CNT_W'(S - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; DONE never accepts so the minimum issue interval is S+2
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // pick the current slice of the latched operands
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int k = 0; k < S; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_s = a_q[k*C +: C];
                b_s = b_q[k*C +: C];
            end
        end
    end

    logic_slice #(.C(C)) u_slice (
        .op  (op_q),
        .a_s (a_s),
        .b_s (b_s),
        .y_s (y_s)
    );

    // operand latches, slice counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt      <= '0;
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            result_q <= '0;
        end else if (state == BUSY) begin
            for (int k = 0; k < S; k++) begin
                if (cnt == CNT_W'(k)) begin
                    result_q[k*C +: C] <= y_s;
                end
            end
            if (!last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign result    = result_q;
    assign out_valid = (state == DONE);
    assign zero      = out_valid && (result_q == '0);
    assign parity    = out_valid && (^result_q);

endmodule
